// File: rtl/pipeline_mem2wb_stage_pkg.sv
// Shared constants, field offsets and skid-buffer state encoding for the MEM->WB stage.
package pipeline_mem2wb_stage_pkg;

    localparam logic [5:0] OP_NOP    = 6'h00;
    localparam logic [5:0] OP_BRANCH = 6'h04;
    localparam logic [5:0] OP_STORE  = 6'h2B;
    localparam logic [5:0] OP_HALT   = 6'h3F;

    localparam int unsigned OpcodeW = 6;
    // Field offsets measured down from the instruction MSB.
    localparam int unsigned OpcodeTopOfs = 1;
    localparam int unsigned RdTopOfs     = 7;

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StOne   = 2'd1,
        StTwo   = 2'd2
    } skid_state_e;

    function automatic logic op_writes_rf(input logic [OpcodeW-1:0] op);
        return !(op inside {OP_NOP, OP_STORE, OP_BRANCH, OP_HALT});
    endfunction

endpackage

// File: rtl/pipeline_mem2wb_stage_skid.sv
// Two-entry valid/ready skid buffer, generic over payload width; in_ready is register-derived.
module wb_skid_buffer
    import pipeline_mem2wb_stage_pkg::*;
#(
    parameter int unsigned DataW = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_i,
    input  logic             enable_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [DataW-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [DataW-1:0] out_data_o
);

    skid_state_e      state_q, state_d;
    logic [DataW-1:0] head_q, head_d;
    logic [DataW-1:0] skid_q, skid_d;
    logic             accept;
    logic             retire;

    assign in_ready_o  = (state_q != StTwo) && enable_i;
    assign out_valid_o = (state_q != StEmpty);
    assign out_data_o  = head_q;
    assign accept      = in_valid_i && in_ready_o;
    assign retire      = out_valid_o && out_ready_i;

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush_i) begin
            // A same-cycle accept is dropped; a same-cycle retire still completes downstream.
            state_d = StEmpty;
        end else begin
            unique case (state_q)
                StEmpty: begin
                    if (accept) begin
                        head_d  = in_data_i;
                        state_d = StOne;
                    end
                end
                StOne: begin
                    if (accept && retire) begin
                        head_d = in_data_i;
                    end else if (accept) begin
                        skid_d  = in_data_i;
                        state_d = StTwo;
                    end else if (retire) begin
                        state_d = StEmpty;
                    end
                end
                StTwo: begin
                    if (retire) begin
                        head_d  = skid_q;
                        state_d = StOne;
                    end
                end
                default: state_d = StEmpty;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StEmpty;
            head_q  <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
        end
    end

endmodule

// File: rtl/pipeline_mem2wb_stage.sv
// MEM->WB stage: skid-buffered handshake, register-file write strobe, flush and sticky halt.
// Optional retire counter enabled by defining WB_RETIRE_COUNT_EN.
module pipeline_mem2wb_stage
    import pipeline_mem2wb_stage_pkg::*;
#(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      instruction_in,
    input  logic [WIDTH-3:0]      progcounter_in,
    input  logic [WIDTH-1:0]      result_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      instruction_out,
    output logic [WIDTH-3:0]      progcounter_out,
    output logic [WIDTH-1:0]      result_out,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [WIDTH-1:0]      rf_wdata,
`ifdef WB_RETIRE_COUNT_EN
    output logic [31:0]           retired_count,
`endif
    output logic                  halted
);

    localparam int unsigned PayW = 3 * WIDTH - 2;

    logic                  started_q;
    logic                  halted_q, halted_d;
    logic [PayW-1:0]       pay_in;
    logic [PayW-1:0]       pay_out;
    logic                  retire;
    logic [OpcodeW-1:0]    opcode;
    logic [REG_ADDR_W-1:0] rd;

    assign pay_in = {instruction_in, progcounter_in, result_in};

    wb_skid_buffer #(
        .DataW(PayW)
    ) u_skid (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush_i    (flush),
        .enable_i   (started_q && !halted_q),
        .in_valid_i (in_valid),
        .in_ready_o (in_ready),
        .in_data_i  (pay_in),
        .out_valid_o(out_valid),
        .out_ready_i(out_ready),
        .out_data_o (pay_out)
    );

    assign instruction_out = pay_out[PayW-1 -: WIDTH];
    assign progcounter_out = pay_out[2*WIDTH-3 -: WIDTH-2];
    assign result_out      = pay_out[WIDTH-1:0];

    assign opcode   = instruction_out[WIDTH-OpcodeTopOfs -: OpcodeW];
    assign rd       = instruction_out[WIDTH-RdTopOfs -: REG_ADDR_W];
    assign retire   = out_valid && out_ready;
    assign rf_we    = retire && op_writes_rf(opcode) && (rd != '0);
    assign rf_waddr = rd;
    assign rf_wdata = result_out;

    assign halted_d = halted_q || (retire && (opcode == OP_HALT));
    assign halted   = halted_q;

    // started_q keeps in_ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            halted_q  <= 1'b0;
        end else begin
            started_q <= 1'b1;
            halted_q  <= halted_d;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else if (retire) begin
            count_q <= count_q + 32'd1;
        end
    end

    assign retired_count = count_q;
`endif

endmodule
